// File: rtl/data_mem.sv
// Byte-strobed 32-bit data memory with zero-fill sweep after reset, write-first reads and sticky error flag.
// Optional macro DATA_MEM_MISALIGN_CHK_EN restricts committed strobes to naturally aligned byte/half/word shapes.
module data_mem #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 2**(ADDR_WIDTH-2)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_read,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        rd_valid,
    output logic        busy,
    output logic        err,
    output logic [15:0] store_cnt
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic [31:0]        data_out_q, data_out_d;
    logic               rd_valid_q, rd_valid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [15:0]        store_cnt_q, store_cnt_d;

    logic [31:0]        mem [DEPTH];
    logic [IDX_W-1:0]   idx_s;
    logic               in_range_s;
    logic               wr_req_s;
    logic [31:0]        rd_word_s;
    logic [31:0]        merged_s;
    logic               mem_we_s;
    logic [IDX_W-1:0]   mem_widx_s;
    logic [31:0]        mem_wdata_s;
    logic               unused_addr_s;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_w[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Strobe shapes allowed to commit; a zero strobe is never a write request.
    function automatic logic strobe_ok(input logic [3:0] strb);
        logic ok;
`ifdef DATA_MEM_MISALIGN_CHK_EN
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
`else
        ok = (strb != 4'b0000);
`endif
        return ok;
    endfunction

    assign idx_s         = data_addr[ADDR_WIDTH-1:2];
    assign unused_addr_s = ^data_addr[1:0];
    assign in_range_s    = (data_addr[31:ADDR_WIDTH] == '0) &&
                           ({{(32-IDX_W){1'b0}}, idx_s} < 32'(DEPTH));
    assign wr_req_s      = (data_write != 4'b0000);
    assign rd_word_s     = mem[idx_s];
    assign merged_s      = merge_lanes(rd_word_s, data_in, data_write);

    // Next-state and datapath decisions for sweep and CPU accesses.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        busy_d      = busy_q;
        err_d       = err_q;
        store_cnt_d = store_cnt_q;
        mem_we_s    = 1'b0;
        mem_widx_s  = idx_s;
        mem_wdata_s = merged_s;
        case (state_q)
            INIT: begin
                mem_we_s    = 1'b1;
                mem_widx_s  = sweep_q;
                mem_wdata_s = 32'h0000_0000;
                if (sweep_q == LAST_IDX) begin
                    state_d = READY;
                    sweep_d = '0;
                    busy_d  = 1'b0;
                end else begin
                    sweep_d = sweep_q + IDX_W'(1);
                    busy_d  = 1'b1;
                end
            end
            READY: begin
                busy_d = 1'b0;
                if (wr_req_s) begin
                    if (in_range_s && strobe_ok(data_write)) begin
                        mem_we_s    = 1'b1;
                        store_cnt_d = (store_cnt_q == 16'hFFFF) ? store_cnt_q
                                                                : store_cnt_q + 16'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
                // A same-cycle write to the same word is returned merged (write-first).
                if (data_read) begin
                    rd_valid_d = 1'b1;
                    if (in_range_s) begin
                        data_out_d = mem_we_s ? merged_s : rd_word_s;
                    end else begin
                        data_out_d = 32'h0000_0000;
                        err_d      = 1'b1;
                    end
                end else begin
                    rd_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
                sweep_d = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= INIT;
            sweep_q     <= '0;
            data_out_q  <= 32'h0000_0000;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            store_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    // Storage array; no reset, contents come only from the sweep and committed stores.
    always_ff @(posedge clk) begin
        if (mem_we_s && rst) begin
            mem[mem_widx_s] <= mem_wdata_s;
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign store_cnt = store_cnt_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus pushes expected read data, a negedge monitor pops on rd_valid.
module tb_data_mem;

`ifdef DATA_MEM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_read = 1'b0;
    logic [31:0] data_addr = 32'h0;
    logic [3:0]  data_write = 4'h0;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        busy;
    logic        err;
    logic [15:0] store_cnt;

    int          tests = 0;
    int          fails = 0;
    int          rd_pushed = 0;
    int          rd_seen = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    data_mem #(.ADDR_WIDTH(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_read  (data_read),
        .data_addr  (data_addr),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .err        (err),
        .store_cnt  (store_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            rd_seen++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: got data 0x%08h with no read pending", data_out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    fails++;
                    $display("FAIL rd_data: got 0x%08h expected 0x%08h", data_out, e);
                end
            end
        end
    end

    // Called at posedge+1; drives one cycle of request then idles the bus.
    task automatic access(input logic rd, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] din, input logic push, input logic [31:0] exp);
        data_read  = rd;
        data_addr  = addr;
        data_write = strb;
        data_in    = din;
        if (push) begin
            exp_q.push_back(exp);
            rd_pushed++;
        end
        @(posedge clk); #1;
        data_read  = 1'b0;
        data_write = 4'h0;
        data_addr  = 32'h0;
        data_in    = 32'h0;
    endtask

    task automatic count_busy(input string name, input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
            else break;
        end
        check(name, 32'(n), 32'(exp_n));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, data_out, 32'h0);
        check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'h0);
        check({tag, "_err"}, {31'd0, err}, 32'h0);
        check({tag, "_store_cnt"}, 32'(store_cnt), 32'h0);
        check({tag, "_busy"}, {31'd0, busy}, 32'h1);
    endtask

    initial begin
        logic [15:0] cnt_before;
        repeat (3) @(posedge clk); #1;
        check_reset_outputs("rst0");

        // Release; a request during the sweep must be ignored, so 1023 busy samples remain.
        rst = 1'b1;
        access(1'b1, 32'h200, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
        count_busy("busy_len_initial", 1023);
        check("init_ignored_cnt", 32'(store_cnt), 32'h0);
        check("init_ignored_err", {31'd0, err}, 32'h0);

        access(1'b1, 32'h3FC, 4'h0, 32'h0, 1'b1, 32'h0000_0000);
        access(1'b1, 32'h200, 4'h0, 32'h0, 1'b1, 32'h0000_0000);

        access(1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
        access(1'b1, 32'h100, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF);
        check("store_cnt_1", 32'(store_cnt), 32'h1);

        access(1'b0, 32'h100, 4'b0010, 32'h00005500, 1'b0, 32'h0);
        access(1'b1, 32'h102, 4'h0, 32'h0, 1'b1, 32'hDEAD55EF);
        check("store_cnt_2", 32'(store_cnt), 32'h2);

        access(1'b1, 32'h104, 4'hF, 32'h12345678, 1'b1, 32'h12345678);
        check("store_cnt_3", 32'(store_cnt), 32'h3);
        repeat (3) @(posedge clk); #1;
        check("data_out_hold", data_out, 32'h12345678);
        check("rd_valid_idle", {31'd0, rd_valid}, 32'h0);

        access(1'b1, 32'h104, 4'b1000, 32'hAB000000, 1'b1, 32'hAB345678);
        check("store_cnt_4", 32'(store_cnt), 32'h4);

        // Strobe 0101 is legal only without the misalignment check.
        access(1'b0, 32'h108, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0);
        access(1'b1, 32'h108, 4'h0, 32'h0, 1'b1, CHK ? 32'h0 : 32'h00BB00DD);
        check("strobe0101_cnt", 32'(store_cnt), CHK ? 32'h4 : 32'h5);
        check("strobe0101_err", {31'd0, err}, CHK ? 32'h1 : 32'h0);

        cnt_before = store_cnt;
        access(1'b0, 32'h0000_2000, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0);
        check("oor_write_err", {31'd0, err}, 32'h1);
        check("oor_write_cnt", 32'(store_cnt), 32'(cnt_before));
        access(1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0000_0000);
        access(1'b1, 32'h0000_2000, 4'h0, 32'h0, 1'b1, 32'h0000_0000);
        access(1'b1, 32'h100, 4'h0, 32'h0, 1'b1, 32'hDEAD55EF);
        @(posedge clk); #1;
        check("err_sticky", {31'd0, err}, 32'h1);

        // Reset with live state, then again mid-sweep; sweep must restart from word 0.
        rst = 1'b0;
        #1;
        check_reset_outputs("rst1");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (300) @(posedge clk); #1;
        check("mid_sweep_busy", {31'd0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst2");
        @(posedge clk); #1;
        rst = 1'b1;
        count_busy("busy_len_restart", 1024);

        access(1'b1, 32'h100, 4'h0, 32'h0, 1'b1, 32'h0000_0000);
        access(1'b1, 32'h104, 4'h0, 32'h0, 1'b1, 32'h0000_0000);
        access(1'b1, 32'h108, 4'h0, 32'h0, 1'b1, 32'h0000_0000);
        repeat (3) @(posedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check("rd_pulse_count", 32'(rd_seen), 32'(rd_pushed));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
